uart_frame_parser: RTL and testbench
====================================

# uart_frame_parser

Downstream consumer of the UART receive path. Pops bytes from the receive FIFO, assembles framed commands (sync, command, length, payload, XOR checksum) and presents each validated frame as a one-cycle strobe with registered command, length and payload fields. Framing errors and inter-byte timeouts abort the frame and are reported. Sits between the UART receiver/FIFO and the application command logic.

## Interface
- `MAX_PAYLOAD`, 8: maximum payload bytes per frame (1..16).
- `SYNC_BYTE`, 8'hAA: frame start marker.
- `TIMEOUT_CYCLES`, 1_000_000: idle cycles tolerated between bytes inside a frame (20 ms at 50 MHz).
- `TO_BITS`, 20: timeout counter width; must hold `TIMEOUT_CYCLES`.
- `clk_50MHz`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rx_empty`  in  1  receive FIFO empty flag.
- `read_data`  in  8  FIFO head byte; valid whenever `rx_empty`=0 (first-word-fall-through).
- `read_uart`  out  1  FIFO pop; byte on `read_data` is consumed in the cycle this is 1.
- `frame_valid`  out  1  one-cycle strobe: new frame on `cmd`/`len`/`payload`.
- `cmd`  out  8  command byte of the last good frame.
- `len`  out  8  payload length of the last good frame.
- `payload`  out  8*MAX_PAYLOAD  payload; byte i at [8i+7:8i]; bytes ≥ `len` are zero.
- `frame_err`  out  1  one-cycle strobe: frame aborted.
- `err_code`  out  2  cause of last abort: 01 length, 10 checksum, 11 timeout; 00 never errored.

## Operation
- `read_uart` = (`rx_empty`=0); combinational. The parser never stalls the FIFO; at most one byte per cycle.
- States:
  - IDLE: consumed byte == `SYNC_BYTE` → CMD; any other byte is discarded.
  - CMD: latch byte into shadow cmd; checksum accumulator = byte → LEN.
  - LEN: byte > `MAX_PAYLOAD` → error 01, IDLE. Byte == 0 → CHK. Otherwise → PAYLOAD, index = 0. Accumulator ^= byte.
  - PAYLOAD: store byte at shadow[index], accumulator ^= byte, index++; after byte `len`-1 → CHK.
  - CHK: byte == accumulator → commit, IDLE. Mismatch → error 10, IDLE.
- A `SYNC_BYTE` value inside CMD/LEN/PAYLOAD/CHK is ordinary data; no resync.
- Commit: registered `cmd`, `len`, `payload` (positions ≥ len forced to zero) and `frame_valid`=1 are updated at the same edge as the CHK→IDLE transition. The shadow buffer is cleared on entry to CMD.
- Timeout: counter runs in CMD/LEN/PAYLOAD/CHK when no byte is consumed. It clears on every consumed byte and in IDLE. When the counter reaches `TIMEOUT_CYCLES`, the next edge → IDLE, `frame_err`=1, `err_code`=11. If a byte arrives in the same cycle the counter reaches the limit, the byte wins and no timeout occurs.
- Outputs hold their last committed values until the next commit. `err_code` holds until the next error.
- A new frame may start on the cycle after commit or abort.

## Timing
- Reset (async assert, sync release): state IDLE, counter 0, `frame_valid`=0, `frame_err`=0, `cmd`=0, `len`=0, `payload`=0, `err_code`=00. `read_uart` follows `rx_empty`, so it is 0 while the FIFO is empty.
- `frame_valid` rises one clock after the cycle in which the checksum byte is popped. `frame_err` rises one clock after the offending byte is popped, or one clock after the timeout limit is reached.
- Minimum frame latency with a full FIFO: 4+`len` pop cycles, then 1 cycle to the strobe.
- Reset asserted mid-frame: partial frame discarded; no strobe.

## Test plan
- FIFO supplies AA 01 02 10 20 33 back-to-back → 6 pops on consecutive cycles; `frame_valid` for 1 cycle; `cmd`=01, `len`=02, `payload`[15:0]=16'h2010, other payload bytes 0.
- Garbage 55 00 then AA 07 00 07 → leading bytes dropped; frame with `len`=0 accepted; `cmd`=07, `payload`=0.
- AA 01 09 … (`len`=9 > 8) → `frame_err`=1, `err_code`=01. The following AA 02 00 02 is parsed correctly.
- AA 01 01 10 00 (bad checksum, expected 10) → `frame_err`, `err_code`=10; `cmd`/`len`/`payload` unchanged.
- AA 01, then FIFO empty for `TIMEOUT_CYCLES` (set to 100) → `frame_err`, `err_code`=11 at cycle 101. Separately, a byte arriving at exactly cycle 100 → no error.
- Reset pulsed after AA 03 → all outputs return to zero; next full frame is accepted normally.

Source files
------------

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: pops bytes from a FWFT receive FIFO and assembles sync/cmd/len/payload/XOR-checksum frames,
// strobing validated frames and reporting length, checksum and inter-byte timeout aborts.
module uart_frame_parser #(
  parameter int         MAX_PAYLOAD    = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hAA,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter int         TO_BITS        = 20
) (
  input  logic                     clk_50MHz,
  input  logic                     reset,
  input  logic                     rx_empty,
  input  logic [7:0]               read_data,
  output logic                     read_uart,
  output logic                     frame_valid,
  output logic [7:0]               cmd,
  output logic [7:0]               len,
  output logic [8*MAX_PAYLOAD-1:0] payload,
  output logic                     frame_err,
  output logic [1:0]               err_code
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK} state_t;
  state_t r_state, w_next;
  logic [TO_BITS-1:0]       r_cnt;
  logic [4:0]               r_idx;
  logic [7:0]               r_acc, r_cmd_sh, r_len_sh;
  logic [8*MAX_PAYLOAD-1:0] r_shadow, r_payload;
  logic [7:0]               r_cmd, r_len;
  logic                     r_fv, r_fe;
  logic [1:0]               r_err;
  logic w_pop, w_start, w_last, w_len_err, w_commit, w_chk_err, w_timeout;
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = w_start ? S_CMD : S_IDLE;
      S_CMD:  w_next = w_pop ? S_LEN : S_CMD;
      S_LEN:  w_next = !w_pop ? S_LEN : w_len_err ? S_IDLE : (read_data == 8'd0) ? S_CHK : S_PAY;
      S_PAY:  w_next = (w_pop && w_last) ? S_CHK : S_PAY;
      S_CHK:  w_next = w_pop ? S_IDLE : S_CHK;
      default: w_next = S_IDLE;
    endcase
    if (w_timeout) w_next = S_IDLE;
  end
  always_comb begin
    read_uart = ~rx_empty;
    w_pop     = ~rx_empty;
    w_start   = (r_state == S_IDLE) && w_pop && (read_data == SYNC_BYTE);
    w_last    = ({3'b000, r_idx} == r_len_sh - 8'd1);
    w_len_err = (r_state == S_LEN) && w_pop && (read_data > 8'(MAX_PAYLOAD));
    w_commit  = (r_state == S_CHK) && w_pop && (read_data == r_acc);
    w_chk_err = (r_state == S_CHK) && w_pop && (read_data != r_acc);
    // an arriving byte always beats the limit
    w_timeout = (r_state != S_IDLE) && !w_pop && (r_cnt == TO_BITS'(TIMEOUT_CYCLES));
  end
  always_ff @(posedge clk_50MHz or negedge reset)
    if (!reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_acc     <= '0;
      r_cmd_sh  <= '0;
      r_len_sh  <= '0;
      r_shadow  <= '0;
      r_payload <= '0;
      r_cmd     <= '0;
      r_len     <= '0;
      r_fv      <= 1'b0;
      r_fe      <= 1'b0;
      r_err     <= 2'b00;
    end else begin
      r_cnt <= (r_state == S_IDLE || w_pop) ? '0 : r_cnt + 1'b1;
      if (w_start) r_shadow <= '0;
      if (r_state == S_CMD && w_pop) begin
        r_cmd_sh <= read_data;
        r_acc    <= read_data;
      end
      if (r_state == S_LEN && w_pop) begin
        r_len_sh <= read_data;
        r_acc    <= r_acc ^ read_data;
        r_idx    <= '0;
      end
      if (r_state == S_PAY && w_pop) begin
        r_acc <= r_acc ^ read_data;
        r_idx <= r_idx + 5'd1;
      end
      for (int i = 0; i < MAX_PAYLOAD; i++)
        if (r_state == S_PAY && w_pop && r_idx == i[4:0]) r_shadow[8*i +: 8] <= read_data;
      r_fv <= w_commit;
      r_fe <= w_len_err | w_chk_err | w_timeout;
      if (w_commit) begin
        r_cmd <= r_cmd_sh;
        r_len <= r_len_sh;
        for (int i = 0; i < MAX_PAYLOAD; i++)
          r_payload[8*i +: 8] <= (i[7:0] < r_len_sh) ? r_shadow[8*i +: 8] : 8'h00;
      end
      if (w_len_err)      r_err <= 2'b01;
      else if (w_chk_err) r_err <= 2'b10;
      else if (w_timeout) r_err <= 2'b11;
    end
  assign frame_valid = r_fv;
  assign frame_err   = r_fe;
  assign err_code    = r_err;
  assign cmd         = r_cmd;
  assign len         = r_len;
  assign payload     = r_payload;
endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: directed frames with hand-computed expectations for the frame parser.
module tb_uart_frame_parser;
  logic        clk_50MHz = 1'b0;
  logic        reset;
  logic        rx_empty;
  logic [7:0]  read_data;
  logic        read_uart;
  logic        frame_valid;
  logic [7:0]  cmd;
  logic [7:0]  len;
  logic [63:0] payload;
  logic        frame_err;
  logic [1:0]  err_code;
  int n_cmp = 0;
  int n_bad = 0;
  int n_fv = 0;
  int n_fe = 0;
  int n_pop = 0;
  int pop0;
  uart_frame_parser #(
    .MAX_PAYLOAD(8), .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(100), .TO_BITS(8)
  ) dut (
    .clk_50MHz(clk_50MHz), .reset(reset), .rx_empty(rx_empty), .read_data(read_data),
    .read_uart(read_uart), .frame_valid(frame_valid), .cmd(cmd), .len(len),
    .payload(payload), .frame_err(frame_err), .err_code(err_code)
  );
  always #5 clk_50MHz = ~clk_50MHz;
  always @(negedge clk_50MHz) begin
    if (frame_valid) n_fv++;
    if (frame_err) n_fe++;
    if (read_uart) n_pop++;
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // bytes are packed first-byte-most-significant in the low n bytes of b
  task automatic put(input logic [63:0] b, input int n);
    for (int k = 0; k < n; k++) begin
      rx_empty  = 1'b0;
      read_data = b[8*(n-1-k) +: 8];
      @(posedge clk_50MHz); #1;
    end
    rx_empty  = 1'b1;
    read_data = 8'h00;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk_50MHz);
    #1;
  endtask
  initial begin
    reset = 1'b0; rx_empty = 1'b1; read_data = 8'h00;
    #1;
    check("rst_fv", frame_valid, 0);
    check("rst_fe", frame_err, 0);
    check("rst_cmd", cmd, 0);
    check("rst_len", len, 0);
    check("rst_pay", payload, 0);
    check("rst_err", err_code, 0);
    check("rst_rd", read_uart, 0);
    repeat (2) @(negedge clk_50MHz);
    reset = 1'b1;
    @(posedge clk_50MHz); #1;
    pop0 = n_pop;
    put({8'hAA, 8'h01, 8'h02, 8'h10, 8'h20, 8'h33}, 6);
    check("t1_pops", n_pop - pop0, 6);
    check("t1_fv", frame_valid, 1);
    check("t1_cmd", cmd, 8'h01);
    check("t1_len", len, 8'h02);
    check("t1_pay", payload, 64'h2010);
    idle(1);
    check("t1_fv_off", frame_valid, 0);
    put({8'hAA, 8'h01, 8'h01, 8'h10, 8'h00}, 5);
    check("t4_fe", frame_err, 1);
    check("t4_fv", frame_valid, 0);
    check("t4_err", err_code, 2'b10);
    check("t4_cmd", cmd, 8'h01);
    check("t4_len", len, 8'h02);
    check("t4_pay", payload, 64'h2010);
    idle(1);
    check("t4_fe_off", frame_err, 0);
    put({8'h55, 8'h00, 8'hAA, 8'h07, 8'h00, 8'h07}, 6);
    check("t2_fv", frame_valid, 1);
    check("t2_cmd", cmd, 8'h07);
    check("t2_len", len, 8'h00);
    check("t2_pay", payload, 0);
    idle(1);
    put({8'hAA, 8'h01, 8'h09}, 3);
    check("t3_fe", frame_err, 1);
    check("t3_err", err_code, 2'b01);
    check("t3_cmd", cmd, 8'h07);
    put({8'hAA, 8'h02, 8'h00, 8'h02}, 4);
    check("t3b_fv", frame_valid, 1);
    check("t3b_cmd", cmd, 8'h02);
    check("t3b_len", len, 8'h00);
    idle(1);
    put({8'hAA, 8'h01}, 2);
    idle(100);
    check("to_early", frame_err, 0);
    idle(1);
    check("to_fe", frame_err, 1);
    check("to_err", err_code, 2'b11);
    idle(1);
    check("to_fe_off", frame_err, 0);
    put({8'hAA, 8'h01}, 2);
    idle(100);
    put({8'h00, 8'h01}, 2);
    check("late_fv", frame_valid, 1);
    check("late_cmd", cmd, 8'h01);
    check("late_len", len, 8'h00);
    check("late_err", err_code, 2'b11);
    idle(1);
    put({8'hAA, 8'h03}, 2);
    reset = 1'b0;
    #1;
    check("mr_cmd", cmd, 0);
    check("mr_len", len, 0);
    check("mr_pay", payload, 0);
    check("mr_err", err_code, 0);
    @(negedge clk_50MHz);
    reset = 1'b1;
    @(posedge clk_50MHz); #1;
    put({8'hAA, 8'h05, 8'h01, 8'h77, 8'h73}, 5);
    check("mr_fv", frame_valid, 1);
    check("mr_cmd2", cmd, 8'h05);
    check("mr_len2", len, 8'h01);
    check("mr_pay2", payload, 64'h77);
    idle(2);
    check("n_fv", n_fv, 5);
    check("n_fe", n_fe, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
